isp8_ienc: RTL and testbench

//  Instruction encoder/loader for the isp8 core. Takes mnemonic-level commands over a valid/ready port.

---
 rtl/isp8_ienc.sv | 198 +++++++++++++++++++
 tb/tb_isp8_ienc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/isp8_ienc.sv
// isp8 instruction encoder/loader: packs mnemonic commands into 18-bit words and writes them to PROM.
// Optional ISP8_IENC_READBACK_EN adds a read-back/verify pass after each write.
module isp8_ienc #(
   parameter int PROM_AW = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [5:0]         cmd_op,
   input  logic               cmd_imm,
   input  logic [4:0]         cmd_rd,
   input  logic [4:0]         cmd_rb,
   input  logic [7:0]         cmd_data,
   input  logic [PROM_AW-1:0] cmd_target,
   input  logic               addr_load,
   input  logic [PROM_AW-1:0] addr_value,
   input  logic               clr_err,
   output logic               prom_we,
   output logic               prom_re,
   output logic [PROM_AW-1:0] prom_addr,
   output logic [17:0]        prom_wdata,
   input  logic [17:0]        prom_rdata,
   output logic               busy,
   output logic               err_op,
   output logic               err_verify,
   output logic               wrapped
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
`ifdef ISP8_IENC_READBACK_EN
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_CHECK = 2'd3;
`endif

   logic [1:0]         state_q, state_d;
   logic [PROM_AW-1:0] ptr_q, ptr_d;
   logic [17:0]        wdata_q, wdata_d;
   logic               err_op_q, err_verify_q, wrapped_q;
   logic               eop_set, ever_set, wrap_set, bump;

   logic [17:0] enc;
   logic        legal;
   logic [5:0]  k;
   logic [11:0] tgt12;
   logic        tgt_ok;

   // Branch targets occupy 12 bits; wider pointers must be sign-compatible with bit 11.
   generate
      if (PROM_AW < 12) begin : g_tgt_narrow
         assign tgt12  = {{(12-PROM_AW){1'b0}}, cmd_target};
         assign tgt_ok = 1'b1;
      end else if (PROM_AW == 12) begin : g_tgt_exact
         assign tgt12  = cmd_target;
         assign tgt_ok = 1'b1;
      end else begin : g_tgt_wide
         assign tgt12  = cmd_target[11:0];
         assign tgt_ok = (cmd_target[PROM_AW-1:12] == {(PROM_AW-12){cmd_target[11]}});
      end
   endgenerate

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      k     = '0;
      if (cmd_op <= 6'd9) begin
         enc[17:14] = cmd_op[3:0];
         enc[13]    = cmd_imm;
         enc[12:8]  = cmd_rd;
         enc[7:0]   = cmd_imm ? cmd_data : {cmd_rb, 3'b000};
      end else if (cmd_op <= 6'd13) begin
         // ror/rorc/rol/rolc map to 00/10/01/11: code offset with its bits swapped
         k          = cmd_op - 6'd10;
         enc[17:14] = 4'b1010;
         enc[12:8]  = cmd_rd;
         enc[7:3]   = cmd_rb;
         enc[1:0]   = {k[0], k[1]};
      end else if (cmd_op <= 6'd19) begin
         k          = cmd_op - 6'd14;
         enc[17:14] = 4'b1011;
         enc[2:0]   = k[2:0];
      end else if (cmd_op <= 6'd27) begin
         k          = cmd_op - 6'd20;
         enc[17:14] = 4'b1011;
         enc[13]    = 1'b1;
         enc[12:8]  = cmd_rd;
         enc[7:3]   = cmd_rb;
         enc[2:0]   = k[2:0];
      end else if (cmd_op <= 6'd31) begin
         k          = cmd_op - 6'd28;
         enc[17:14] = 4'b1100;
         enc[13:12] = k[1:0];
         enc[11:0]  = tgt12;
         legal      = tgt_ok;
      end else if (cmd_op == 6'd32) begin
         enc[17:14] = 4'b1110;
         enc[13:12] = 2'b11;
         enc[11:0]  = tgt12;
         legal      = tgt_ok;
      end else if (cmd_op <= 6'd36) begin
         k          = cmd_op - 6'd33;
         enc[17:14] = 4'b1101;
         enc[13:12] = k[1:0];
         enc[11:0]  = tgt12;
         legal      = tgt_ok;
      end else if (cmd_op == 6'd37) begin
         enc[17:14] = 4'b1110;
         enc[11:0]  = tgt12;
         legal      = tgt_ok;
      end else if (cmd_op <= 6'd39) begin
         k          = cmd_op - 6'd37;
         enc[17:14] = 4'b1110;
         enc[13:12] = k[1:0];
      end else begin
         legal = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      wdata_d  = wdata_q;
      eop_set  = 1'b0;
      ever_set = 1'b0;
      bump     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (addr_load) begin
               ptr_d = addr_value;
            end else if (cmd_valid) begin
               if (legal) begin
                  wdata_d = enc;
                  state_d = S_WRITE;
               end else begin
                  eop_set = 1'b1;
               end
            end
         end
`ifdef ISP8_IENC_READBACK_EN
         S_WRITE: state_d = S_READ;
         S_READ:  state_d = S_CHECK;
         S_CHECK: begin
            ever_set = (prom_rdata != wdata_q);
            bump     = 1'b1;
            state_d  = S_IDLE;
         end
`else
         S_WRITE: begin
            bump    = 1'b1;
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      wrap_set = bump & (ptr_q == {PROM_AW{1'b1}});
      if (bump) ptr_d = ptr_q + PROM_AW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         wdata_q      <= '0;
         err_op_q     <= 1'b0;
         err_verify_q <= 1'b0;
         wrapped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         wdata_q      <= wdata_d;
         err_op_q     <= eop_set  | (err_op_q     & ~clr_err);
         err_verify_q <= ever_set | (err_verify_q & ~clr_err);
         wrapped_q    <= wrap_set | (wrapped_q    & ~clr_err);
      end
   end

   // Strobes are gated by reset so a word caught mid-write is never committed.
   assign cmd_ready  = (state_q == S_IDLE) & ~addr_load & rst_n;
   assign prom_we    = (state_q == S_WRITE) & rst_n;
`ifdef ISP8_IENC_READBACK_EN
   assign prom_re    = (state_q == S_READ) & rst_n;
   assign err_verify = err_verify_q;
`else
   logic rdata_unused;
   logic everq_unused;
   assign rdata_unused = ^prom_rdata;
   assign everq_unused = err_verify_q;
   assign prom_re      = 1'b0;
   assign err_verify   = 1'b0;
`endif
   assign prom_addr  = ptr_q;
   assign prom_wdata = wdata_q;
   assign busy       = (state_q != S_IDLE);
   assign err_op     = err_op_q;
   assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_isp8_ienc.sv
// Directed bench for isp8_ienc: vector table for encodings plus hand sequences for pointer/error corners.
module tb_isp8_ienc;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_imm;
   logic [5:0]    cmd_op;
   logic [4:0]    cmd_rd, cmd_rb;
   logic [7:0]    cmd_data;
   logic [AW-1:0] cmd_target, addr_value, prom_addr;
   logic          addr_load, clr_err;
   logic          prom_we, prom_re, busy, err_op, err_verify, wrapped;
   logic [17:0]   prom_wdata, prom_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   isp8_ienc #(.PROM_AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_rd(cmd_rd), .cmd_rb(cmd_rb),
      .cmd_data(cmd_data), .cmd_target(cmd_target), .addr_load(addr_load),
      .addr_value(addr_value), .clr_err(clr_err), .prom_we(prom_we), .prom_re(prom_re),
      .prom_addr(prom_addr), .prom_wdata(prom_wdata), .prom_rdata(prom_rdata),
      .busy(busy), .err_op(err_op), .err_verify(err_verify), .wrapped(wrapped)
   );

   typedef struct {
      logic [5:0]  op;
      logic        imm;
      logic [4:0]  rd;
      logic [4:0]  rb;
      logic [7:0]  data;
      logic [9:0]  tgt;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [5:0] op, input logic imm, input logic [4:0] rd,
                       input logic [4:0] rb, input logic [7:0] data, input logic [9:0] tgt);
      cmd_op = op; cmd_imm = imm; cmd_rd = rd; cmd_rb = rb; cmd_data = data; cmd_target = tgt;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_write(output bit ok, output logic [AW-1:0] a, output logic [17:0] d);
      ok = 1'b0; a = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
         if (prom_we) begin
            ok = 1'b1; a = prom_addr; d = prom_wdata;
            break;
         end
         tick;
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!cmd_ready && n < 8) begin
         tick;
         n++;
      end
      if (!cmd_ready) chk({nm, " idle timeout"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic write_chk(input string nm, input logic [AW-1:0] ea, input logic [17:0] ed);
      bit            ok;
      logic [AW-1:0] a;
      logic [17:0]   d;
      wait_write(ok, a, d);
      chk({nm, " we"}, 32'(ok), 32'd1);
      chk({nm, " addr"}, 32'(a), 32'(ea));
      chk({nm, " wdata"}, 32'(d), 32'(ed));
      wait_idle(nm);
   endtask

   initial begin
      vecs[0]  = '{6'd2,  1'b1, 5'd3,  5'd0,  8'h5A, 10'h000, 18'h0A35A};
      vecs[1]  = '{6'd37, 1'b0, 5'd0,  5'd0,  8'h00, 10'h1F3, 18'h381F3};
      vecs[2]  = '{6'd38, 1'b0, 5'd9,  5'd9,  8'hFF, 10'h155, 18'h39000};
      vecs[3]  = '{6'd11, 1'b0, 5'd1,  5'd2,  8'h00, 10'h000, 18'h28112};
      vecs[4]  = '{6'd0,  1'b0, 5'h1F, 5'h15, 8'hFF, 10'h000, 18'h01FA8};
      vecs[5]  = '{6'd7,  1'b1, 5'd0,  5'd5,  8'h81, 10'h000, 18'h1E081};
      vecs[6]  = '{6'd12, 1'b0, 5'd2,  5'd3,  8'h00, 10'h000, 18'h28219};
      vecs[7]  = '{6'd13, 1'b0, 5'd0,  5'd0,  8'h00, 10'h000, 18'h28003};
      vecs[8]  = '{6'd19, 1'b1, 5'd7,  5'd9,  8'hAA, 10'h3FF, 18'h2C005};
      vecs[9]  = '{6'd23, 1'b0, 5'd4,  5'd6,  8'h00, 10'h000, 18'h2E433};
      vecs[10] = '{6'd31, 1'b0, 5'd0,  5'd0,  8'h00, 10'h3FF, 18'h333FF};
      vecs[11] = '{6'd32, 1'b0, 5'd0,  5'd0,  8'h00, 10'h0AA, 18'h3B0AA};
      vecs[12] = '{6'd33, 1'b0, 5'd0,  5'd0,  8'h00, 10'h123, 18'h34123};
      vecs[13] = '{6'd39, 1'b0, 5'd0,  5'd0,  8'h00, 10'h2BC, 18'h3A000};
      vecs[14] = '{6'd36, 1'b0, 5'd0,  5'd0,  8'h00, 10'h000, 18'h37000};
      vecs[15] = '{6'd27, 1'b0, 5'd1,  5'd1,  8'h00, 10'h000, 18'h2E10F};
      vecs[16] = '{6'd14, 1'b1, 5'd3,  5'd3,  8'h77, 10'h000, 18'h2C000};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = 1'b0; cmd_rd = '0; cmd_rb = '0;
      cmd_data = '0; cmd_target = '0; addr_load = 1'b0; addr_value = '0; clr_err = 1'b0;
      prom_rdata = '0;
      tick; tick;
      chk("rst ready", 32'(cmd_ready), 32'd0);
      chk("rst we", 32'(prom_we), 32'd0);
      chk("rst addr", 32'(prom_addr), 32'd0);
      chk("rst wdata", 32'(prom_wdata), 32'd0);
      chk("rst busy/err", 32'({busy, err_op, err_verify, wrapped, prom_re}), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post-rst ready", 32'(cmd_ready), 32'd1);

      // Encoding table, written back-to-back from address 0
      for (int i = 0; i < 17; i++) begin
         prom_rdata = vecs[i].exp;
         send(vecs[i].op, vecs[i].imm, vecs[i].rd, vecs[i].rb, vecs[i].data, vecs[i].tgt);
         write_chk($sformatf("vec%0d", i), AW'(i), vecs[i].exp);
      end
      chk("table flags", 32'({err_op, err_verify, wrapped}), 32'd0);
      chk("table ptr", 32'(prom_addr), 32'd17);

      // Illegal op: accepted, flagged, nothing written
      send(6'd45, 1'b0, 5'd0, 5'd0, 8'd0, 10'd0);
      chk("illegal we", 32'(prom_we), 32'd0);
      chk("illegal busy", 32'(busy), 32'd0);
      chk("illegal err", 32'(err_op), 32'd1);
      chk("illegal ptr", 32'(prom_addr), 32'd17);
      clr_err = 1'b1; tick; clr_err = 1'b0;
      chk("clr err_op", 32'(err_op), 32'd0);
      clr_err = 1'b1;
      send(6'd63, 1'b0, 5'd0, 5'd0, 8'd0, 10'd0);
      clr_err = 1'b0;
      chk("set beats clr", 32'(err_op), 32'd1);
      clr_err = 1'b1; tick; clr_err = 1'b0;
      chk("clr err_op 2", 32'(err_op), 32'd0);

      // Pointer wrap at top of PROM
      addr_load = 1'b1; addr_value = 10'h3FF; tick; addr_load = 1'b0;
      chk("load 3FF", 32'(prom_addr), 32'h3FF);
      prom_rdata = 18'h2C001;
      send(6'd15, 1'b0, 5'd0, 5'd0, 8'd0, 10'd0);
      write_chk("setc@3FF", 10'h3FF, 18'h2C001);
      chk("wrap ptr", 32'(prom_addr), 32'd0);
      chk("wrapped", 32'(wrapped), 32'd1);
      clr_err = 1'b1; tick; clr_err = 1'b0;
      chk("clr wrapped", 32'(wrapped), 32'd0);

      // addr_load and cmd_valid together: load wins, command taken next cycle
      prom_rdata = 18'h12233;
      addr_load = 1'b1; addr_value = 10'h100;
      cmd_op = 6'd4; cmd_imm = 1'b1; cmd_rd = 5'd2; cmd_rb = 5'd0; cmd_data = 8'h33; cmd_valid = 1'b1;
      #1;
      chk("load+valid ready", 32'(cmd_ready), 32'd0);
      tick;
      addr_load = 1'b0;
      #1;
      chk("load+valid no we", 32'(prom_we), 32'd0);
      chk("load+valid ptr", 32'(prom_addr), 32'h100);
      chk("load+valid ready2", 32'(cmd_ready), 32'd1);
      tick;
      cmd_valid = 1'b0;
      write_chk("mov@100", 10'h100, 18'h12233);
      chk("ptr 101", 32'(prom_addr), 32'h101);

      // addr_load while busy is ignored
      send(6'd4, 1'b1, 5'd2, 5'd0, 8'h33, 10'd0);
      chk("busy in write", 32'(busy), 32'd1);
      addr_load = 1'b1; addr_value = 10'h055; tick; addr_load = 1'b0;
      wait_idle("busy load");
      chk("busy load ignored", 32'(prom_addr), 32'h102);

      // Read-back path (verify mismatch when enabled; inert otherwise)
      prom_rdata = 18'h00000;
      send(6'd2, 1'b1, 5'd3, 5'd0, 8'h5A, 10'd0);
      chk("rb we", 32'(prom_we), 32'd1);
      chk("rb wdata", 32'(prom_wdata), 32'h0A35A);
      tick;
`ifdef ISP8_IENC_READBACK_EN
      chk("rb re", 32'(prom_re), 32'd1);
      chk("rb re addr", 32'(prom_addr), 32'h102);
      chk("rb ready read", 32'(cmd_ready), 32'd0);
      tick;
      chk("rb ready check", 32'(cmd_ready), 32'd0);
      chk("rb ptr in check", 32'(prom_addr), 32'h102);
      tick;
      chk("rb ready 4cyc", 32'(cmd_ready), 32'd1);
      chk("err_verify", 32'(err_verify), 32'd1);
`else
      chk("no re", 32'(prom_re), 32'd0);
      chk("ready 2cyc", 32'(cmd_ready), 32'd1);
      chk("err_verify tied", 32'(err_verify), 32'd0);
`endif
      chk("rb ptr", 32'(prom_addr), 32'h103);

      // Reset during WRITE: word dropped, pointer cleared
      send(6'd8, 1'b1, 5'd1, 5'd0, 8'h10, 10'd0);
      rst_n = 1'b0;
      #1;
      chk("rst mid we", 32'(prom_we), 32'd0);
      tick;
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid ptr", 32'(prom_addr), 32'd0);
      chk("rst mid ready", 32'(cmd_ready), 32'd0);
      chk("rst mid flags", 32'({err_op, err_verify, wrapped}), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst mid ready2", 32'(cmd_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
